// File: rtl/pwp_pkg.sv
// Shared definitions for the bit-serial subtractor.
// FSM state encoding used by the control path.
package pwp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_full_subtractor.sv
// Single-bit full subtractor slice: diff = x - y - bin.
// Combinational; fed by the operand shift-register LSBs.
module bit_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor d = a - b, one bit per clock.
// Optional signed overflow output when SERIAL_SUB_OVF_EN is defined.
module n_bit_serial_subtractor
  import pwp_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-2:0]  r_res;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_d;
  logic          r_borrow;

  logic          w_diff;
  logic          w_bout;
  logic          w_acc;
  logic          w_last;
  logic [N-1:0]  w_res_next;

  bit_full_subtractor u_bfs (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_br),
    .diff (w_diff),
    .bout (w_bout)
  );

  assign w_acc      = in_valid && (r_state == IDLE);
  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_res_next = {w_diff, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
    end else if (w_acc) begin
      r_sa  <= a;
      r_sb  <= b;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_res <= w_res_next[N-1:1];
      r_br  <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      // Results only move on entry to DONE so they hold through IDLE
      if (w_last) begin
        r_d      <= w_res_next;
        r_borrow <= w_bout;
      end
    end
  end

  assign d      = r_d;
  assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb;
  logic r_bmsb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_acc) begin
      r_amsb <= a[N-1];
      r_bmsb <= b[N-1];
    end else if (w_last) begin
      r_ovf <= (r_amsb ^ r_bmsb) & (w_diff ^ r_amsb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/n_bit_serial_subtractor.md
# n_bit_serial_subtractor

Bit-serial, multi-cycle N-bit subtractor computing d = a − b one bit per clock with a registered borrow. It is the subtract-direction counterpart of the datapath's combinational n-bit adder. It is used where area matters more than latency, such as the divide/compare helper path of the processor. Operands arrive and results leave on valid/ready handshakes.

## Interface
- N, default 8: operand and result width; legal range N ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  minuend, sampled on accept.
- b  input  N  subtrahend, sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- d  output  N  (a − b) mod 2^N.
- borrow  output  1  1 iff a < b (unsigned).
- ovf  output  1  signed overflow; present only with the configuration macro.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. When in_valid is high at an edge, load a into sa and b into sb. Clear the borrow flop br and the bit counter cnt. Latch a[N-1] and b[N-1]. Go to SHIFT.
  - SHIFT: each cycle, compute diff = sa[0] ^ sb[0] ^ br and br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
    - Shift sa and sb right by 1.
    - Shift diff into the MSB of the result register (right shift).
    - Increment cnt. When cnt = N−1 at the edge, go to DONE.
  - DONE: out_valid = 1. d holds the result register and borrow = br. When out_ready is high at an edge, go to IDLE.
- in_valid is ignored outside IDLE. Operands are not captured and there is no queueing.
- d, borrow and ovf change only on the transition into DONE. They hold their values through IDLE until the next DONE.
- Counter width is clog2(N). Wrap-around of cnt is impossible because the FSM leaves SHIFT at N−1.
- rst has priority over everything, including in the middle of SHIFT or DONE. The in-flight operation is discarded and never reported.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, d = 0, borrow = 0, ovf = 0, and all internal registers = 0.
- Accept edge E0 (in_valid & in_ready). The FSM is in SHIFT for cycles E0+1 … E0+N. out_valid rises after edge E0+N.
- Result-to-accept: if out_ready is high in the first DONE cycle, in_ready is high in the next cycle. Minimum period per operation is N+2 cycles.
- out_ready held low: out_valid and d stay stable indefinitely.
- in_ready and out_valid are decoded purely from the state register. They have no combinational paths from in_valid or out_ready.

## Configuration
- SERIAL_SUB_OVF_EN defined: the ovf port exists. In DONE, ovf = (a_msb ≠ b_msb) & (d[N-1] ≠ a_msb), using the MSBs latched at accept. It is registered on entry to DONE.
- Not defined: there is no ovf port and no latched-MSB flops. All other behaviour is identical.

## Structure
- Shared package pwp_pkg holds the FSM state typedef (IDLE/SHIFT/DONE, 2-bit encoding).
- Sub-module bit_full_subtractor (inputs x, y, bin; outputs diff, bout) computes the single-bit slice. It is instantiated once and fed by the shift-register LSBs and br.

## Test plan
- N=8, a=0x05, b=0x03, out_ready=1 → out_valid after 8 cycles in SHIFT; d=0x02, borrow=0.
- a=0x00, b=0x01 → d=0xFF, borrow=1. Then a=0xFF, b=0xFF → d=0x00, borrow=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → d=0x7F, borrow=0, ovf=1. Also a=0x7F, b=0xFF → d=0x80, borrow=1, ovf=1.
- a=0xAA, b=0x55, out_ready low for 5 cycles with in_valid toggling → d=0x55 stable, in_ready=0, no extra operation accepted. out_ready=1 → in_ready=1 on the next cycle.
- rst pulsed during SHIFT cycle 3 of a=0x10, b=0x20 → next cycle IDLE, out_valid=0, d=0. Then a=0x10, b=0x10 → d=0x00, borrow=0.
- Back-to-back random operands, out_ready=1 for 1000 operations → each result matches a−b mod 256, period exactly 10 cycles.
